// File: rtl/dut_run_ctrl_if.sv
// Host request/response channel plus the core control/status lines of the run sequencer.
// The slave modport is the sequencer; the master modport is the host and core side.
interface dut_run_ctrl_if #(
  parameter int unsigned CYC_W = 16
) ();

  // Request channel
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_prog;
  logic             abort;

  // Core control and status
  logic             dut_reset;
  logic             dut_start;
  logic [11:0]      dut_pc_init;
  logic             dut_done;

  // Response channel
  logic             busy;
  logic             resp_valid;
  logic             resp_ready;
  logic [1:0]       resp_prog;
  logic [CYC_W-1:0] resp_cycles;
  logic [1:0]       resp_status;

  modport master (
    output req_valid,
    output req_prog,
    output abort,
    output dut_done,
    output resp_ready,
    input  req_ready,
    input  dut_reset,
    input  dut_start,
    input  dut_pc_init,
    input  busy,
    input  resp_valid,
    input  resp_prog,
    input  resp_cycles,
    input  resp_status
  );

  modport slave (
    input  req_valid,
    input  req_prog,
    input  abort,
    input  dut_done,
    input  resp_ready,
    output req_ready,
    output dut_reset,
    output dut_start,
    output dut_pc_init,
    output busy,
    output resp_valid,
    output resp_prog,
    output resp_cycles,
    output resp_status
  );

endinterface

// File: rtl/dut_run_ctrl.sv
// Run sequencer for the single-cycle core: reset/start window, timed run, valid/ready response.
// Every output is a register loaded from the next-state logic.
module dut_run_ctrl #(
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned CYC_W        = 16,
  parameter int unsigned TIMEOUT      = 50000,
  parameter logic [11:0] PROG0_PC     = 12'h000,
  parameter logic [11:0] PROG1_PC     = 12'h000,
  parameter logic [11:0] PROG2_PC     = 12'h000,
  parameter logic [11:0] PROG3_PC     = 12'h000
) (
  input logic           clk_i,
  input logic           reset_i,
  dut_run_ctrl_if.slave bus_io
);

  localparam int unsigned ScntW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [ScntW-1:0] ScntLast   = ScntW'(START_CYCLES - 1);
  localparam logic [CYC_W-1:0] TimeoutVal = CYC_W'(TIMEOUT);

  localparam logic [1:0] StatusDone    = 2'b00;
  localparam logic [1:0] StatusTimeout = 2'b01;
  localparam logic [1:0] StatusAbort   = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StRun,
    StResp
  } state_e;

  state_e           state_q, state_d;
  logic [ScntW-1:0] scnt_q, scnt_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [1:0]       prog_q, prog_d;

  logic             req_ready_q, req_ready_d;
  logic             busy_q, busy_d;
  logic             dut_reset_q, dut_reset_d;
  logic             dut_start_q, dut_start_d;
  logic [11:0]      pc_init_q, pc_init_d;
  logic             resp_valid_q, resp_valid_d;
  logic [1:0]       resp_prog_q, resp_prog_d;
  logic [CYC_W-1:0] resp_cycles_q, resp_cycles_d;
  logic [1:0]       resp_status_q, resp_status_d;

  logic [CYC_W-1:0] cyc_inc;

  function automatic logic [11:0] prog_pc(input logic [1:0] idx);
    logic [11:0] pc;
    unique case (idx)
      2'd0:    pc = PROG0_PC;
      2'd1:    pc = PROG1_PC;
      2'd2:    pc = PROG2_PC;
      default: pc = PROG3_PC;
    endcase
    return pc;
  endfunction

  // TIMEOUT < 2^CYC_W, so the run counter stops before it can wrap.
  assign cyc_inc = cyc_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    scnt_d        = scnt_q;
    cyc_d         = cyc_q;
    prog_d        = prog_q;
    dut_reset_d   = 1'b0;
    dut_start_d   = 1'b0;
    pc_init_d     = 12'h000;
    resp_prog_d   = resp_prog_q;
    resp_cycles_d = resp_cycles_q;
    resp_status_d = resp_status_q;

    unique case (state_q)
      StIdle: begin
        if (bus_io.req_valid) begin
          state_d     = StStart;
          prog_d      = bus_io.req_prog;
          scnt_d      = '0;
          dut_reset_d = 1'b1;
          dut_start_d = 1'b1;
          pc_init_d   = prog_pc(bus_io.req_prog);
        end
      end

      StStart: begin
        if (scnt_q == ScntLast) begin
          state_d = StRun;
          cyc_d   = '0;
        end else begin
          scnt_d      = scnt_q + 1'b1;
          dut_start_d = 1'b1;
          pc_init_d   = prog_pc(prog_q);
        end
      end

      StRun: begin
        if (bus_io.abort) begin
          state_d       = StResp;
          resp_prog_d   = prog_q;
          resp_cycles_d = cyc_inc;
          resp_status_d = StatusAbort;
        end else if (bus_io.dut_done) begin
          state_d       = StResp;
          resp_prog_d   = prog_q;
          resp_cycles_d = cyc_inc;
          resp_status_d = StatusDone;
        end else if (cyc_inc == TimeoutVal) begin
          state_d       = StResp;
          resp_prog_d   = prog_q;
          resp_cycles_d = TimeoutVal;
          resp_status_d = StatusTimeout;
        end else begin
          cyc_d = cyc_inc;
        end
      end

      StResp: begin
        if (bus_io.resp_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    // Status outputs follow the state being entered so they line up with it.
    req_ready_d  = (state_d == StIdle);
    busy_d       = (state_d != StIdle);
    resp_valid_d = (state_d == StResp);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      scnt_q        <= '0;
      cyc_q         <= '0;
      prog_q        <= 2'd0;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      dut_reset_q   <= 1'b0;
      dut_start_q   <= 1'b0;
      pc_init_q     <= 12'h000;
      resp_valid_q  <= 1'b0;
      resp_prog_q   <= 2'd0;
      resp_cycles_q <= '0;
      resp_status_q <= 2'd0;
    end else begin
      state_q       <= state_d;
      scnt_q        <= scnt_d;
      cyc_q         <= cyc_d;
      prog_q        <= prog_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      dut_reset_q   <= dut_reset_d;
      dut_start_q   <= dut_start_d;
      pc_init_q     <= pc_init_d;
      resp_valid_q  <= resp_valid_d;
      resp_prog_q   <= resp_prog_d;
      resp_cycles_q <= resp_cycles_d;
      resp_status_q <= resp_status_d;
    end
  end

  assign bus_io.req_ready   = req_ready_q;
  assign bus_io.busy        = busy_q;
  assign bus_io.dut_reset   = dut_reset_q;
  assign bus_io.dut_start   = dut_start_q;
  assign bus_io.dut_pc_init = pc_init_q;
  assign bus_io.resp_valid  = resp_valid_q;
  assign bus_io.resp_prog   = resp_prog_q;
  assign bus_io.resp_cycles = resp_cycles_q;
  assign bus_io.resp_status = resp_status_q;

endmodule
